// File: rtl/gnw_pkg.sv
// Shared types and helpers for the gnw upload path.
// Holds the responder FSM states and the byte-lane select.
package gnw_pkg;

  localparam int GNW_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } upl_state_t;

  function automatic logic [7:0] gnw_byte_sel(
    input logic [15:0] w,
    input logic        odd
  );
    return odd ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/gnw_sdram_upload.sv
// HPS upload responder: serves ioctl byte reads from the SDRAM ROM image.
// A one-word cache answers the second byte of each word without SDRAM.
module gnw_sdram_upload
  import gnw_pkg::*;
#(
  parameter int          ADDR_W    = GNW_ADDR_W,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_rd,
  input  logic [15:0]       sd_dout,
  input  logic              sd_ready,
  output logic              sd_busy,
  output logic              err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  upl_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-2:0] tag_q;
  logic [15:0]       word_q;
  logic              valid_q;
  logic [7:0]        din_q;
  logic              busy_q;
  logic              err_q;
  logic [TW-1:0]     timer_q;

  logic rd_ok;
  logic hit;
  logic tmo;

  // Reads in the upload rising-edge cycle are dropped until sd_busy is up.
  assign rd_ok = ioctl_rd && ioctl_upload && busy_q;
  assign hit   = valid_q && (tag_q == ioctl_addr[ADDR_W-1:1]);
  assign tmo   = (timer_q == T_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_ok && !hit) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (sd_ready || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!ioctl_upload) state_d = IDLE;
  end

  always_comb begin
    ioctl_wait  = (state_q != IDLE);
    sd_rd       = (state_q == ISSUE);
    sd_addr     = {addr_q[ADDR_W-1:1], 1'b0};
    ioctl_din   = din_q;
    sd_busy     = busy_q;
    err_timeout = err_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      tag_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      busy_q <= ioctl_upload;
      if (!(ioctl_upload && busy_q)) valid_q <= 1'b0;
      if (ioctl_upload && !busy_q) err_q <= 1'b0;
      if (ioctl_upload) begin
        unique case (state_q)
          IDLE: begin
            if (rd_ok && hit) begin
              din_q <= gnw_byte_sel(word_q, ioctl_addr[0]);
            end else if (rd_ok) begin
              addr_q <= ioctl_addr;
            end
          end
          ISSUE: timer_q <= '0;
          WAIT: begin
            if (sd_ready) begin
              word_q  <= sd_dout;
              tag_q   <= addr_q[ADDR_W-1:1];
              valid_q <= 1'b1;
              din_q   <= gnw_byte_sel(sd_dout, addr_q[0]);
            end else if (tmo) begin
              din_q   <= FILL_BYTE;
              err_q   <= 1'b1;
              valid_q <= 1'b0;
            end else if (timer_q != '1) begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gnw_sdram_upload.sv
// Bench for gnw_sdram_upload: 3-cycle SDRAM model plus byte scoreboard.
// TIMEOUT is shortened to 16 so the timeout path runs quickly.
module tb_gnw_sdram_upload;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [24:0] sd_addr;
  logic        sd_rd;
  logic [15:0] sd_dout = '0;
  logic        sd_ready = 1'b0;
  logic        sd_busy;
  logic        err_timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_cyc = 0;
  int ready_cyc = -100;
  int cnt = 0;
  bit sd_en = 1'b1;
  logic [24:0] m_addr = '0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  gnw_sdram_upload #(
    .ADDR_W   (25),
    .TIMEOUT  (16),
    .FILL_BYTE(8'hFF)
  ) dut (
    .clk_sys     (clk),
    .reset_n     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .sd_addr     (sd_addr),
    .sd_rd       (sd_rd),
    .sd_dout     (sd_dout),
    .sd_ready    (sd_ready),
    .sd_busy     (sd_busy),
    .err_timeout (err_timeout)
  );

  function automatic logic [15:0] wd(input logic [24:0] a);
    case (a)
      25'h0000000: return 16'hBEEF;
      25'h0000002: return 16'h1234;
      25'h1FFFFFE: return 16'h5A3C;
      default:     return {a[8:1], ~a[8:1]};
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    logic [15:0] w;
    logic [24:0] wa;
    wa = {a[24:1], 1'b0};
    w = wd(wa);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM: read sampled on edge E, ready pulse sampled on edge E+3.
  always @(posedge clk) begin
    sd_ready <= 1'b0;
    if (sd_rd && sd_en) begin
      cnt    <= 2;
      m_addr <= sd_addr;
    end else if (cnt == 1) begin
      cnt      <= 0;
      sd_ready <= 1'b1;
      sd_dout  <= wd(m_addr);
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (sd_rd) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    cyc++;
  end

  always @(negedge clk) if (sd_ready) ready_cyc = cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_rd(input string tag, input logic [24:0] a,
                       input logic [7:0] exp, input bit miss);
    int n0;
    int n;
    logic [24:0] wa;
    n0 = rd_cnt;
    wa = {a[24:1], 1'b0};
    @(negedge clk);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    ioctl_rd = 1'b0;
    check({tag, "_wait1"}, 32'(ioctl_wait), 32'(miss));
    if (miss) begin
      check({tag, "_sdrd"}, 32'(sd_rd), 32'd1);
      check({tag, "_sdaddr"}, 32'(sd_addr), 32'(wa));
    end
    n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(ioctl_wait), 32'd0);
    if (miss && sd_en) check({tag, "_lat"}, cyc, ready_cyc + 1);
    if (miss && !sd_en) check({tag, "_tmo_lat"}, cyc, rd_cyc + 17);
    check({tag, "_din"}, 32'(ioctl_din), 32'(sb_q.pop_front()));
    check({tag, "_nrd"}, rd_cnt - n0, miss ? 1 : 0);
  endtask

  initial begin
    int n0;
    int n;
    logic [7:0] old;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    #12;
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_sdaddr", 32'(sd_addr), 32'd0);
    check("rst_sdrd", 32'(sd_rd), 32'd0);
    check("rst_busy", 32'(sd_busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // read while no session is open
    @(negedge clk);
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    check("nosess_wait", 32'(ioctl_wait), 32'd0);
    check("nosess_din", 32'(ioctl_din), 32'd0);

    // read in the rising-edge cycle of ioctl_upload is dropped
    @(negedge clk);
    ioctl_upload = 1'b1;
    ioctl_rd     = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    check("edge_busy", 32'(sd_busy), 32'd1);
    check("edge_wait", 32'(ioctl_wait), 32'd0);
    @(negedge clk);
    check("edge_nrd", rd_cnt, 0);

    do_rd("a0", 25'h0, 8'hEF, 1'b1);
    do_rd("a1", 25'h1, 8'hBE, 1'b0);
    do_rd("a2", 25'h2, 8'h34, 1'b1);
    do_rd("top", 25'h1FFFFFF, 8'h5A, 1'b1);
    do_rd("toph", 25'h1FFFFFE, 8'h3C, 1'b0);

    sd_en = 1'b0;
    do_rd("tmo", 25'h100, 8'hFF, 1'b1);
    check("tmo_err", 32'(err_timeout), 32'd1);
    sd_en = 1'b1;
    do_rd("sticky", 25'h2, 8'h34, 1'b1);
    check("sticky_err", 32'(err_timeout), 32'd1);
    @(negedge clk);
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk);
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    check("sess_err", 32'(err_timeout), 32'd0);

    // drop the session while waiting on SDRAM
    old = ioctl_din;
    n0 = rd_cnt;
    @(negedge clk);
    ioctl_addr = 25'h4;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    @(negedge clk);
    ioctl_upload = 1'b0;
    @(negedge clk);
    check("abort_wait", 32'(ioctl_wait), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_din", 32'(ioctl_din), 32'(old));
    check("abort_wait2", 32'(ioctl_wait), 32'd0);
    check("abort_nrd", rd_cnt - n0, 1);
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    do_rd("reread", 25'h4, exp_byte(25'h4), 1'b1);

    // second strobe while stalled must not start another access
    n0 = rd_cnt;
    @(negedge clk);
    ioctl_addr = 25'h6;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    @(negedge clk);
    ioctl_addr = 25'h8;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dbl_done", 32'(ioctl_wait), 32'd0);
    check("dbl_din", 32'(ioctl_din), 32'(exp_byte(25'h6)));
    check("dbl_nrd", rd_cnt - n0, 1);
    do_rd("dbl_hit", 25'h7, exp_byte(25'h7), 1'b0);

    // asynchronous reset in the middle of a miss
    @(negedge clk);
    ioctl_addr = 25'hA;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wait", 32'(ioctl_wait), 32'd0);
    check("arst_din", 32'(ioctl_din), 32'd0);
    check("arst_sdaddr", 32'(sd_addr), 32'd0);
    check("arst_sdrd", 32'(sd_rd), 32'd0);
    check("arst_busy", 32'(sd_busy), 32'd0);
    check("arst_err", 32'(err_timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_idle", 32'(ioctl_wait), 32'd0);
    do_rd("arst_inv", 25'h6, exp_byte(25'h6), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
